stopwatch_counter: RTL and testbench
====================================

Name: stopwatch_counter

Overview:
- Consumer of the stopwatch tick generator's output. Each single-cycle `tick` is one centisecond.
- Keeps a BCD time of MM:SS.cc, from 00:00.00 to 59:59.99.
- Start/stop, clear and lap control come in as single-cycle pulses. These are already debounced and edge-detected upstream.
- Feeds the display driver registered BCD digits plus status flags.

Parameters:
- WRAP_EN, 1: behaviour at 59:59.99. 1 = wrap to 00:00.00 and set `wrapped`. 0 = saturate and go to PAUSED.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- tick  in  1  one-cycle pulse, one per centisecond
- start_stop  in  1  one-cycle pulse; toggles run/pause
- clear  in  1  one-cycle pulse; zero the time and return to IDLE
- lap  in  1  one-cycle pulse; toggle display freeze while RUNNING
- min_tens  out  4  BCD digit, 0-5
- min_ones  out  4  BCD digit, 0-9
- sec_tens  out  4  BCD digit, 0-5
- sec_ones  out  4  BCD digit, 0-9
- cs_tens  out  4  BCD digit, 0-9
- cs_ones  out  4  BCD digit, 0-9
- running  out  1  high in RUNNING
- lap_hold  out  1  high while the display is frozen
- wrapped  out  1  sticky; set on wrap, cleared by clear or rst

Behaviour:
- Reset (rst high, asynchronous):
  - All internal digits and all output digits = 0.
  - State = IDLE; running = 0, lap_hold = 0, wrapped = 0.
- State machine (registered):
  - IDLE: start_stop -> RUNNING.
  - RUNNING: start_stop -> PAUSED. Each tick increments the internal count.
  - PAUSED: start_stop -> RUNNING. Ticks are ignored.
  - Any state: clear -> IDLE.
- Tick handling:
  - A tick counts only if the state at that clock edge is RUNNING.
  - A tick in the same cycle as start_stop uses the pre-transition state. Example: RUNNING + tick + start_stop counts the tick, then pauses.
- Counting:
  - Cascaded BCD digits: cs_ones 0-9, cs_tens 0-9, sec_ones 0-9, sec_tens 0-5, min_ones 0-9, min_tens 0-5.
  - Carry ripples combinationally within the same cycle.
  - No binary intermediate; every digit stays a legal BCD value at all times.
- Latency: a tick sampled at edge N shows on the digit outputs after edge N (one register stage). No output depends combinationally on inputs.
- Overflow, tick at 59:59.99 while RUNNING:
  - WRAP_EN=1: digits -> 00:00.00, wrapped <= 1, stays RUNNING.
  - WRAP_EN=0: digits hold 59:59.99, state -> PAUSED, wrapped stays 0. A later start_stop re-enters RUNNING; further ticks keep it saturated and return it to PAUSED.
- Lap:
  - lap while RUNNING and lap_hold=0: lap_hold <= 1. Output digits freeze at the internal value as of that edge; internal counting continues.
  - lap while lap_hold=1, in any state: lap_hold <= 0. Outputs show the live count from the next edge.
  - lap in IDLE or PAUSED with lap_hold=0: ignored.
  - start_stop does not change lap_hold.
  - Lap and tick in the same cycle: the frozen value includes that tick.
- Clear:
  - Highest priority. Overrides start_stop, lap and tick in the same cycle.
  - Next edge: internal and output digits = 0, IDLE, lap_hold = 0, wrapped = 0.
- rst asserted mid-count: immediate asynchronous return to the reset values. No tick is counted on the release edge.

Decomposition:
- Package stopwatch_pkg:
  - state typedef {IDLE, RUNNING, PAUSED}
  - BCD_W = 4
  - digit limit constants CS_MAX = 9, SEC_TENS_MAX = 5, MIN_TENS_MAX = 5
- Sub-module bcd_digit, parameter MAX, instantiated 6 times:
  - ports clk, rst, clr, inc, digit[3:0], carry
  - carry = inc && digit == MAX; on inc, digit goes MAX -> 0

Test Plan:
- Reset then start_stop, then 100 ticks -> outputs 00:01.00, running = 1.
- Preload via 5999 ticks to 00:59.99, then 1 tick -> 01:00.00, with every digit carry observed in the same cycle.
- WRAP_EN=1 at 59:59.99 + tick -> 00:00.00, wrapped = 1, running = 1.
- WRAP_EN=0 at 59:59.99 + tick -> 59:59.99 held, running = 0.
- RUNNING at 00:00.42: lap -> outputs frozen at 00:00.42, lap_hold = 1. After 30 more ticks, outputs still show 00:00.42. Second lap -> 00:00.72, lap_hold = 0.
- Same cycle: clear + start_stop + tick while RUNNING at 00:05.00 -> 00:00.00, IDLE, running = 0.
- Same cycle: start_stop + tick while RUNNING at 00:00.09 -> 00:00.10, then PAUSED; 5 further ticks leave 00:00.10.
- rst pulse mid-count at 00:03.17 -> all outputs 0 immediately without a clock edge, IDLE.

Source files
------------

// File: rtl/stopwatch_counter_pkg.sv
// Shared types and limits for the MM:SS.cc stopwatch counter.
// Digits are plain BCD nibbles; the time bundle packs them MSD first.
package stopwatch_pkg;

   localparam int BCD_W        = 4;
   localparam int CS_MAX       = 9;
   localparam int SEC_TENS_MAX = 5;
   localparam int MIN_TENS_MAX = 5;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RUNNING = 2'd1,
      PAUSED  = 2'd2
   } state_t;

   typedef logic [BCD_W-1:0] bcd_t;

   typedef struct packed {
      bcd_t min_tens;
      bcd_t min_ones;
      bcd_t sec_tens;
      bcd_t sec_ones;
      bcd_t cs_tens;
      bcd_t cs_ones;
   } bcd_time_t;

   localparam bcd_time_t TIME_MAX = '{
      min_tens: bcd_t'(MIN_TENS_MAX),
      min_ones: bcd_t'(CS_MAX),
      sec_tens: bcd_t'(SEC_TENS_MAX),
      sec_ones: bcd_t'(CS_MAX),
      cs_tens:  bcd_t'(CS_MAX),
      cs_ones:  bcd_t'(CS_MAX)
   };

   // Value a digit takes after this edge, given its inc and carry.
   function automatic bcd_t bcd_next(bcd_t d, logic inc, logic carry);
      bcd_t r;
      r = d;
      if (inc) begin
         r = carry ? '0 : d + bcd_t'(1);
      end
      return r;
   endfunction

endpackage

// File: rtl/stopwatch_counter_digit.sv
// One cascadable BCD digit with synchronous clear.
// carry is combinational so a whole rollover ripples in one cycle.
module bcd_digit
   import stopwatch_pkg::*;
#(
   parameter int MAX = CS_MAX
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             inc,
   output logic [BCD_W-1:0] digit,
   output logic             carry
);

   localparam bcd_t MAXV = bcd_t'(MAX);

   assign carry = inc && (digit == MAXV);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         digit <= '0;
      end else if (clr) begin
         digit <= '0;
      end else if (inc) begin
         digit <= carry ? '0 : digit + bcd_t'(1);
      end
   end

endmodule

// File: rtl/stopwatch_counter.sv
// Centisecond stopwatch: BCD MM:SS.cc counter with run/pause,
// lap freeze and wrap-or-saturate at 59:59.99.
module stopwatch_counter
   import stopwatch_pkg::*;
#(
   parameter bit WRAP_EN = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             tick,
   input  logic             start_stop,
   input  logic             clear,
   input  logic             lap,
   output logic [BCD_W-1:0] min_tens,
   output logic [BCD_W-1:0] min_ones,
   output logic [BCD_W-1:0] sec_tens,
   output logic [BCD_W-1:0] sec_ones,
   output logic [BCD_W-1:0] cs_tens,
   output logic [BCD_W-1:0] cs_ones,
   output logic             running,
   output logic             lap_hold,
   output logic             wrapped
);

   state_t    state;
   bcd_time_t cnt;
   bcd_time_t nxt;
   bcd_time_t disp;

   bcd_t d_mt, d_mo, d_st, d_so, d_ct, d_co;
   logic [5:0] inc;
   logic [5:0] cy;

   logic tick_run;
   logic at_max;
   logic sat_hit;

   assign cnt = {d_mt, d_mo, d_st, d_so, d_ct, d_co};

   assign tick_run = tick && (state == RUNNING) && !clear;
   assign at_max   = (cnt == TIME_MAX);
   assign sat_hit  = tick_run && at_max && !WRAP_EN;

   // Saturating mode blocks the increment so no digit moves.
   assign inc = {cy[4:0], tick_run && !sat_hit};

   bcd_digit #(.MAX(CS_MAX)) u_cs_ones (
      .clk   (clk),
      .rst   (rst),
      .clr   (clear),
      .inc   (inc[0]),
      .digit (d_co),
      .carry (cy[0])
   );

   bcd_digit #(.MAX(CS_MAX)) u_cs_tens (
      .clk   (clk),
      .rst   (rst),
      .clr   (clear),
      .inc   (inc[1]),
      .digit (d_ct),
      .carry (cy[1])
   );

   bcd_digit #(.MAX(CS_MAX)) u_sec_ones (
      .clk   (clk),
      .rst   (rst),
      .clr   (clear),
      .inc   (inc[2]),
      .digit (d_so),
      .carry (cy[2])
   );

   bcd_digit #(.MAX(SEC_TENS_MAX)) u_sec_tens (
      .clk   (clk),
      .rst   (rst),
      .clr   (clear),
      .inc   (inc[3]),
      .digit (d_st),
      .carry (cy[3])
   );

   bcd_digit #(.MAX(CS_MAX)) u_min_ones (
      .clk   (clk),
      .rst   (rst),
      .clr   (clear),
      .inc   (inc[4]),
      .digit (d_mo),
      .carry (cy[4])
   );

   bcd_digit #(.MAX(MIN_TENS_MAX)) u_min_tens (
      .clk   (clk),
      .rst   (rst),
      .clr   (clear),
      .inc   (inc[5]),
      .digit (d_mt),
      .carry (cy[5])
   );

   always_comb begin
      nxt          = cnt;
      nxt.cs_ones  = bcd_next(d_co, inc[0], cy[0]);
      nxt.cs_tens  = bcd_next(d_ct, inc[1], cy[1]);
      nxt.sec_ones = bcd_next(d_so, inc[2], cy[2]);
      nxt.sec_tens = bcd_next(d_st, inc[3], cy[3]);
      nxt.min_ones = bcd_next(d_mo, inc[4], cy[4]);
      nxt.min_tens = bcd_next(d_mt, inc[5], cy[5]);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         running  <= 1'b0;
         lap_hold <= 1'b0;
         wrapped  <= 1'b0;
         disp     <= '0;
      end else if (clear) begin
         state    <= IDLE;
         running  <= 1'b0;
         lap_hold <= 1'b0;
         wrapped  <= 1'b0;
         disp     <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (start_stop) begin
                  state   <= RUNNING;
                  running <= 1'b1;
               end
            end
            RUNNING: begin
               if (start_stop || sat_hit) begin
                  state   <= PAUSED;
                  running <= 1'b0;
               end
            end
            PAUSED: begin
               if (start_stop) begin
                  state   <= RUNNING;
                  running <= 1'b1;
               end
            end
            default: begin
               state   <= IDLE;
               running <= 1'b0;
            end
         endcase

         // Carry out of the top digit only happens on a wrap.
         if (cy[5]) begin
            wrapped <= 1'b1;
         end

         if (lap) begin
            if (lap_hold) begin
               lap_hold <= 1'b0;
            end else if (state == RUNNING) begin
               lap_hold <= 1'b1;
            end
         end

         // Freezing captures this edge's count, including its tick.
         if (!lap_hold || lap) begin
            disp <= nxt;
         end
      end
   end

   assign min_tens = disp.min_tens;
   assign min_ones = disp.min_ones;
   assign sec_tens = disp.sec_tens;
   assign sec_ones = disp.sec_ones;
   assign cs_tens  = disp.cs_tens;
   assign cs_ones  = disp.cs_ones;

endmodule

// File: tb/tb_stopwatch_counter.sv
// Bench for stopwatch_counter: one wrapping and one saturating instance
// on shared stimulus, checked against an integer-centisecond model.
module tb_stopwatch_counter;

   localparam int ST_IDLE  = 0;
   localparam int ST_RUN   = 1;
   localparam int ST_PAUSE = 2;
   localparam int MAXCS    = 359999;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic tick = 1'b0;
   logic start_stop = 1'b0;
   logic clear = 1'b0;
   logic lap = 1'b0;

   logic [3:0] w_mt, w_mo, w_st, w_so, w_ct, w_co;
   logic [3:0] s_mt, s_mo, s_st, s_so, s_ct, s_co;
   logic w_run, w_lh, w_wr;
   logic s_run, s_lh, s_wr;

   logic [23:0] pre;

   int n_checks = 0;
   int n_errors = 0;

   int m_cnt [2];
   int m_st [2];
   int m_disp [2];
   bit m_lh [2];
   bit m_wr [2];

   always #5 clk = ~clk;

   stopwatch_counter #(.WRAP_EN(1'b1)) u_wrap (
      .clk        (clk),
      .rst        (rst),
      .tick       (tick),
      .start_stop (start_stop),
      .clear      (clear),
      .lap        (lap),
      .min_tens   (w_mt),
      .min_ones   (w_mo),
      .sec_tens   (w_st),
      .sec_ones   (w_so),
      .cs_tens    (w_ct),
      .cs_ones    (w_co),
      .running    (w_run),
      .lap_hold   (w_lh),
      .wrapped    (w_wr)
   );

   stopwatch_counter #(.WRAP_EN(1'b0)) u_sat (
      .clk        (clk),
      .rst        (rst),
      .tick       (tick),
      .start_stop (start_stop),
      .clear      (clear),
      .lap        (lap),
      .min_tens   (s_mt),
      .min_ones   (s_mo),
      .sec_tens   (s_st),
      .sec_ones   (s_so),
      .cs_tens    (s_ct),
      .cs_ones    (s_co),
      .running    (s_run),
      .lap_hold   (s_lh),
      .wrapped    (s_wr)
   );

   function automatic logic [23:0] to_bcd(int cs);
      int m, s, c;
      m = cs / 6000;
      s = (cs / 100) % 60;
      c = cs % 100;
      return {4'(m / 10), 4'(m % 10), 4'(s / 10),
              4'(s % 10), 4'(c / 10), 4'(c % 10)};
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_cnt[i]  = 0;
         m_st[i]   = ST_IDLE;
         m_disp[i] = 0;
         m_lh[i]   = 1'b0;
         m_wr[i]   = 1'b0;
      end
   endtask

   task automatic model_step(bit t, bit s, bit c, bit l);
      for (int i = 0; i < 2; i++) begin
         bit sat;
         bit held;
         sat  = 1'b0;
         held = m_lh[i] && !l;
         if (c) begin
            m_cnt[i]  = 0;
            m_st[i]   = ST_IDLE;
            m_disp[i] = 0;
            m_lh[i]   = 1'b0;
            m_wr[i]   = 1'b0;
         end else begin
            if (t && m_st[i] == ST_RUN) begin
               if (m_cnt[i] == MAXCS) begin
                  if (i == 0) begin
                     m_cnt[i] = 0;
                     m_wr[i]  = 1'b1;
                  end else begin
                     sat = 1'b1;
                  end
               end else begin
                  m_cnt[i]++;
               end
            end
            if (l) begin
               if (m_lh[i]) m_lh[i] = 1'b0;
               else if (m_st[i] == ST_RUN) m_lh[i] = 1'b1;
            end
            if (!held) m_disp[i] = m_cnt[i];
            if (s) m_st[i] = (m_st[i] == ST_RUN) ? ST_PAUSE : ST_RUN;
            if (sat) m_st[i] = ST_PAUSE;
         end
      end
   endtask

   task automatic check_all();
      chk("wrap_time", {8'd0, w_mt, w_mo, w_st, w_so, w_ct, w_co},
          {8'd0, to_bcd(m_disp[0])});
      chk("wrap_running", 32'(w_run), 32'(m_st[0] == ST_RUN));
      chk("wrap_lap_hold", 32'(w_lh), 32'(m_lh[0]));
      chk("wrap_wrapped", 32'(w_wr), 32'(m_wr[0]));
      chk("sat_time", {8'd0, s_mt, s_mo, s_st, s_so, s_ct, s_co},
          {8'd0, to_bcd(m_disp[1])});
      chk("sat_running", 32'(s_run), 32'(m_st[1] == ST_RUN));
      chk("sat_lap_hold", 32'(s_lh), 32'(m_lh[1]));
      chk("sat_wrapped", 32'(s_wr), 32'(m_wr[1]));
   endtask

   task automatic step(bit t, bit s, bit c, bit l);
      tick       = t;
      start_stop = s;
      clear      = c;
      lap        = l;
      @(posedge clk);
      model_step(t, s, c, l);
      @(negedge clk);
      check_all();
      tick       = 1'b0;
      start_stop = 1'b0;
      clear      = 1'b0;
      lap        = 1'b0;
   endtask

   task automatic ticks(int n);
      for (int k = 0; k < n; k++) step(1'b1, 1'b0, 1'b0, 1'b0);
   endtask

   // Loads both counters directly; reaching 59:59.99 by ticking is too slow.
   task automatic preload(int cs);
      pre = to_bcd(cs);
      force u_wrap.u_min_tens.digit = pre[23:20];
      force u_wrap.u_min_ones.digit = pre[19:16];
      force u_wrap.u_sec_tens.digit = pre[15:12];
      force u_wrap.u_sec_ones.digit = pre[11:8];
      force u_wrap.u_cs_tens.digit  = pre[7:4];
      force u_wrap.u_cs_ones.digit  = pre[3:0];
      force u_sat.u_min_tens.digit  = pre[23:20];
      force u_sat.u_min_ones.digit  = pre[19:16];
      force u_sat.u_sec_tens.digit  = pre[15:12];
      force u_sat.u_sec_ones.digit  = pre[11:8];
      force u_sat.u_cs_tens.digit   = pre[7:4];
      force u_sat.u_cs_ones.digit   = pre[3:0];
      #1;
      release u_wrap.u_min_tens.digit;
      release u_wrap.u_min_ones.digit;
      release u_wrap.u_sec_tens.digit;
      release u_wrap.u_sec_ones.digit;
      release u_wrap.u_cs_tens.digit;
      release u_wrap.u_cs_ones.digit;
      release u_sat.u_min_tens.digit;
      release u_sat.u_min_ones.digit;
      release u_sat.u_sec_tens.digit;
      release u_sat.u_sec_ones.digit;
      release u_sat.u_cs_tens.digit;
      release u_sat.u_cs_ones.digit;
      m_cnt[0] = cs;
      m_cnt[1] = cs;
      step(1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   typedef struct {
      bit t;
      bit s;
      bit c;
      bit l;
      int exp_cs;
      bit exp_run;
      bit exp_lh;
   } vec_t;

   vec_t vt [13];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      vt[0]  = '{0, 1, 0, 0, 0, 1, 0};
      vt[1]  = '{1, 0, 0, 0, 1, 1, 0};
      vt[2]  = '{1, 1, 0, 0, 2, 0, 0};
      vt[3]  = '{1, 0, 0, 0, 2, 0, 0};
      vt[4]  = '{0, 1, 0, 0, 2, 1, 0};
      vt[5]  = '{1, 0, 0, 1, 3, 1, 1};
      vt[6]  = '{1, 0, 0, 0, 3, 1, 1};
      vt[7]  = '{1, 0, 0, 0, 3, 1, 1};
      vt[8]  = '{0, 0, 0, 1, 5, 1, 0};
      vt[9]  = '{0, 1, 0, 1, 5, 0, 1};
      vt[10] = '{0, 0, 0, 1, 5, 0, 0};
      vt[11] = '{0, 0, 0, 1, 5, 0, 0};
      vt[12] = '{1, 1, 1, 1, 0, 0, 0};

      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_all();
      rst = 1'b0;
      @(negedge clk);
      check_all();

      // Directed vector table against fixed expectations.
      for (int i = 0; i < 13; i++) begin
         step(vt[i].t, vt[i].s, vt[i].c, vt[i].l);
         chk($sformatf("vec%0d_time", i),
             {8'd0, w_mt, w_mo, w_st, w_so, w_ct, w_co},
             {8'd0, to_bcd(vt[i].exp_cs)});
         chk($sformatf("vec%0d_running", i), 32'(w_run), 32'(vt[i].exp_run));
         chk($sformatf("vec%0d_lap_hold", i), 32'(w_lh), 32'(vt[i].exp_lh));
      end

      // 100 ticks make one second.
      step(0, 1, 0, 0);
      ticks(100);
      chk("one_second", {8'd0, w_mt, w_mo, w_st, w_so, w_ct, w_co},
          32'h0000_0100);
      chk("one_second_running", 32'(w_run), 32'd1);

      // Full carry chain into the minutes digit.
      step(0, 0, 1, 0);
      step(0, 1, 0, 0);
      ticks(5999);
      chk("pre_minute", {8'd0, w_mt, w_mo, w_st, w_so, w_ct, w_co},
          32'h0000_5999);
      tick = 1'b1;
      #1;
      chk("carry_chain",
          {26'd0, u_wrap.u_min_tens.carry, u_wrap.u_min_ones.carry,
           u_wrap.u_sec_tens.carry, u_wrap.u_sec_ones.carry,
           u_wrap.u_cs_tens.carry, u_wrap.u_cs_ones.carry},
          32'b001111);
      step(1, 0, 0, 0);
      chk("one_minute", {8'd0, w_mt, w_mo, w_st, w_so, w_ct, w_co},
          32'h0001_0000);

      // Top of range: wrap in one instance, saturate in the other.
      preload(MAXCS);
      step(1, 0, 0, 0);
      chk("wrap_zero", {8'd0, w_mt, w_mo, w_st, w_so, w_ct, w_co}, 32'd0);
      chk("wrap_flag", 32'(w_wr), 32'd1);
      chk("wrap_stays_running", 32'(w_run), 32'd1);
      chk("sat_hold", {8'd0, s_mt, s_mo, s_st, s_so, s_ct, s_co},
          32'h0059_5999);
      chk("sat_paused", 32'(s_run), 32'd0);
      chk("sat_no_wrap_flag", 32'(s_wr), 32'd0);
      step(0, 1, 0, 0);
      step(1, 0, 0, 0);
      step(1, 0, 0, 0);
      chk("sat_reclamp", {8'd0, s_mt, s_mo, s_st, s_so, s_ct, s_co},
          32'h0059_5999);

      // Lap freeze and release.
      step(0, 0, 1, 0);
      step(0, 1, 0, 0);
      ticks(42);
      step(0, 0, 0, 1);
      chk("lap_freeze", {8'd0, w_mt, w_mo, w_st, w_so, w_ct, w_co},
          32'h0000_0042);
      chk("lap_hold_set", 32'(w_lh), 32'd1);
      ticks(30);
      chk("lap_still_frozen", {8'd0, w_mt, w_mo, w_st, w_so, w_ct, w_co},
          32'h0000_0042);
      step(0, 0, 0, 1);
      chk("lap_release", {8'd0, w_mt, w_mo, w_st, w_so, w_ct, w_co},
          32'h0000_0072);
      chk("lap_hold_clr", 32'(w_lh), 32'd0);

      // Clear beats start_stop and tick.
      step(0, 0, 1, 0);
      step(0, 1, 0, 0);
      ticks(500);
      step(1, 1, 1, 0);
      chk("clear_prio_time", {8'd0, w_mt, w_mo, w_st, w_so, w_ct, w_co},
          32'd0);
      chk("clear_prio_running", 32'(w_run), 32'd0);

      // Tick with start_stop counts, then pauses.
      step(0, 1, 0, 0);
      ticks(9);
      step(1, 1, 0, 0);
      chk("ss_tick_time", {8'd0, w_mt, w_mo, w_st, w_so, w_ct, w_co},
          32'h0000_0010);
      ticks(5);
      chk("paused_ignores", {8'd0, w_mt, w_mo, w_st, w_so, w_ct, w_co},
          32'h0000_0010);
      chk("paused_running", 32'(w_run), 32'd0);

      // Asynchronous reset mid-count.
      step(0, 0, 1, 0);
      step(0, 1, 0, 0);
      ticks(317);
      #1;
      rst = 1'b1;
      #1;
      chk("async_rst_time", {8'd0, w_mt, w_mo, w_st, w_so, w_ct, w_co}, 32'd0);
      chk("async_rst_running", 32'(w_run), 32'd0);
      chk("async_rst_sat_time", {8'd0, s_mt, s_mo, s_st, s_so, s_ct, s_co},
          32'd0);
      model_reset();
      @(posedge clk);
      @(negedge clk);
      tick = 1'b1;
      rst  = 1'b0;
      @(posedge clk);
      model_step(1, 0, 0, 0);
      @(negedge clk);
      check_all();
      tick = 1'b0;

      // Randomized traffic, periodically parked near the top of range.
      for (int i = 0; i < 3000; i++) begin
         if (i % 500 == 250) preload(MAXCS - int'($urandom_range(0, 120)));
         step($urandom_range(0, 99) < 70, $urandom_range(0, 99) < 3,
              $urandom_range(0, 199) < 1, $urandom_range(0, 99) < 4);
      end

      $display("Simulation finished: %0d checks, %0d errors",
               n_checks, n_errors);
      $finish;
   end

endmodule
